// File: rtl/alu_pipe_hs_if.sv
// Handshake bundle for alu_pipe_hs.
//   master : upstream/downstream side (drives operation and OutReady)
//   slave  : the ALU (drives InReady, OutValid, DataOut, Zero, Overflow)
// Overflow exists only when ALU_OVF_EN is defined.
interface alu_pipe_hs_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic [SHW-1:0]   Shamt;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] DataOut;
  logic             Zero;
`ifdef ALU_OVF_EN
  logic             Overflow;

  modport master (
    output InValid, Signal, DataA, DataB, Shamt, OutReady,
    input  InReady, OutValid, DataOut, Zero, Overflow
  );
  modport slave (
    input  InValid, Signal, DataA, DataB, Shamt, OutReady,
    output InReady, OutValid, DataOut, Zero, Overflow
  );
`else
  modport master (
    output InValid, Signal, DataA, DataB, Shamt, OutReady,
    input  InReady, OutValid, DataOut, Zero
  );
  modport slave (
    input  InValid, Signal, DataA, DataB, Shamt, OutReady,
    output InReady, OutValid, DataOut, Zero
  );
`endif
endinterface

// File: rtl/alu_pipe_hs.sv
// Registered EX-stage ALU with valid/ready on both sides.
// AND/OR/ADD/SUB/SLT/SLTU complete in one cycle; SRL shifts one bit per
// cycle. The result is held until the consumer takes it.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous reset, active-low
//   bus      alu_pipe_hs_if.slave (InValid/InReady, Signal, DataA, DataB,
//            Shamt, OutValid/OutReady, DataOut, Zero, optional Overflow)
// Build option: define ALU_OVF_EN to add the registered signed-overflow flag.
//
// state | meaning
// IDLE  | no result pending, ready for an operation
// SHIFT | SRL in progress, input stalled
// HOLD  | result presented; new op accepted only when it is consumed
module alu_pipe_hs #(
  parameter int WIDTH = 32
) (
  input logic          Clk,
  input logic          Reset_n,
  alu_pipe_hs_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SRL  = 6'b000010;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] add_w, res, sreg_nx;
  logic [WIDTH:0]   sub_w;
  logic             sub_ovf, in_ready, accept, is_srl, load_res, load_sh;

  assign add_w = bus.DataA + bus.DataB;
  // Bit WIDTH is the carry out of A + ~B + 1; it is clear exactly when A < B unsigned.
  assign sub_w = {1'b0, bus.DataA} + {1'b0, ~bus.DataB} + {{WIDTH{1'b0}}, 1'b1};
  assign sub_ovf = (bus.DataA[WIDTH-1] ^ bus.DataB[WIDTH-1]) &
                   (sub_w[WIDTH-1] ^ bus.DataA[WIDTH-1]);
  assign sreg_nx = sreg_q >> 1;
  assign is_srl  = (bus.Signal == F_SRL);

  assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.OutReady);
  assign accept   = bus.InValid & in_ready;

  always_comb begin
    res = '0;
    case (bus.Signal)
      F_AND:   res = bus.DataA & bus.DataB;
      F_OR:    res = bus.DataA | bus.DataB;
      F_ADD:   res = add_w;
      F_SUB:   res = sub_w[WIDTH-1:0];
      F_SLT:   res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
      F_SLTU:  res = {{(WIDTH-1){1'b0}}, ~sub_w[WIDTH]};
      F_SRL:   res = bus.DataB;  // only used when Shamt is zero
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    load_res = 1'b0;
    load_sh  = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (is_srl && (bus.Shamt != '0)) begin
            state_d = SHIFT;
            sreg_d  = bus.DataB;
            cnt_d   = bus.Shamt;
          end else begin
            state_d  = HOLD;
            load_res = 1'b1;
          end
        end else if ((state_q == HOLD) && bus.OutReady) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sreg_d = sreg_nx;
        cnt_d  = cnt_q - SHW'(1);
        // The last shift goes straight into the output register.
        if (cnt_q == SHW'(1)) begin
          state_d = HOLD;
          load_sh = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    zero_d = zero_q;
    if (load_res) begin
      data_d = res;
      zero_d = (res == '0);
    end else if (load_sh) begin
      data_d = sreg_nx;
      zero_d = (sreg_nx == '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = (state_q == HOLD);
  assign bus.DataOut  = data_q;
  assign bus.Zero     = zero_q;

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic add_ovf;

  assign add_ovf = ~(bus.DataA[WIDTH-1] ^ bus.DataB[WIDTH-1]) &
                   (add_w[WIDTH-1] ^ bus.DataA[WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (load_res) begin
      ovf_d = ((bus.Signal == F_ADD) & add_ovf) | ((bus.Signal == F_SUB) & sub_ovf);
    end else if (load_sh) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.Overflow = ovf_q;
`endif
endmodule
